// File: rtl/wb_spi_slave_pkg.sv
// Purpose : register map, STATUS bit positions and status layout shared by RTL and bus drivers.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package wb_spi_slave_pkg;

    // Register indices, selected by byte address bits [5:2].
    localparam logic [3:0] REG_STATUS = 4'd0;
    localparam logic [3:0] REG_RXDATA = 4'd1;
    localparam logic [3:0] REG_TXDATA = 4'd2;
    localparam logic [3:0] REG_CTRL   = 4'd3;

    // STATUS bit positions.
    localparam int ST_RX_VALID = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_UNDERRUN = 4;
    localparam int ST_SELECTED = 5;

    // Packed so that field order matches the ST_* positions above (rx_valid is bit 0).
    typedef struct packed {
        logic selected;
        logic underrun;
        logic overrun;
        logic tx_empty;
        logic rx_full;
        logic rx_valid;
    } status_t;

    // Byte address of a register index.
    function automatic logic [31:0] reg_addr(input logic [3:0] idx);
        return {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/wb_spi_slave_if.sv
// Purpose : Wishbone classic slave port bundle (strobe/cycle/we, address, data, ack).
// Latency : n/a (wires only).
// Backpressure: slave stalls the master by withholding wb_ack_o.
interface wb_spi_slave_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_spi_slave_core.sv
// Purpose : SPI mode-0 slave datapath: pin synchronizers, SCLK edge detect, rx/tx shifters, bit counter, word start.
// Latency : pin to edge pulse 3 clk; rx_push in the cycle of the final rise pulse; miso 1 clk after a fall pulse.
// Backpressure: none, the external master owns the pace; the caller must accept rx_push every cycle.
// Ports: clk/reset; sclk_i/ss_n_i/mosi_i async pins; tx_full_i/tx_word_i holding register view;
//        rx_word_o/rx_push_o received word; tx_load_req_o word-start strobe; underrun_pulse_o; selected_o; miso_o.
module spi_slave_core #(
    parameter int d_width = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk_i,
    input  logic               ss_n_i,
    input  logic               mosi_i,
    input  logic               tx_full_i,
    input  logic [d_width-1:0] tx_word_i,
    output logic [d_width-1:0] rx_word_o,
    output logic               rx_push_o,
    output logic               tx_load_req_o,
    output logic               underrun_pulse_o,
    output logic               selected_o,
    output logic               miso_o
);
    localparam int CW = $clog2(d_width + 1);

    // [1:0] are the synchronizer stages, [2] the delayed copy for edge detection.
    logic [2:0]         sclk_sync_q, sclk_sync_d;
    logic [2:0]         ss_sync_q, ss_sync_d;
    logic [1:0]         mosi_sync_q, mosi_sync_d;
    logic               active_q, active_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [d_width-1:0] rx_sh_q, rx_sh_d;
    logic [d_width-1:0] tx_sh_q, tx_sh_d;

    logic               sclk_rise, sclk_fall, ss_low, ss_fall, en, word_done, word_start;
    logic [d_width-1:0] rx_next;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk_i};
        ss_sync_d   = {ss_sync_q[1:0], ss_n_i};
        mosi_sync_d = {mosi_sync_q[0], mosi_i};
        sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
        ss_low      = ~ss_sync_q[1];
        ss_fall     = ss_low & ss_sync_q[2];
        // active_q is only set by a seen falling edge, so a frame already in
        // progress when reset releases is ignored until ss_n goes high again.
        en          = active_q & ss_low;
        rx_next     = d_width'({rx_sh_q, mosi_sync_q[1]});
        word_done   = en & sclk_rise & (cnt_q == CW'(d_width - 1));
        word_start  = ss_fall | word_done;

        active_d = active_q;
        cnt_d    = cnt_q;
        rx_sh_d  = rx_sh_q;
        tx_sh_d  = tx_sh_q;
        if (!ss_low) begin
            // Deselect discards any partial word in both directions.
            active_d = 1'b0;
            cnt_d    = '0;
            rx_sh_d  = '0;
            tx_sh_d  = '0;
        end else begin
            if (ss_fall) active_d = 1'b1;
            if (en && sclk_rise) begin
                rx_sh_d = rx_next;
                cnt_d   = word_done ? '0 : cnt_q + CW'(1);
            end
            // The fall that follows a word's last rise must not shift: the
            // shifter was just reloaded and its MSB is the next word's first bit.
            if (en && sclk_fall && cnt_q != '0) tx_sh_d = tx_sh_q << 1;
            if (word_start) tx_sh_d = tx_full_i ? tx_word_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
        end
    end

    assign rx_word_o        = rx_next;
    assign rx_push_o        = word_done;
    assign tx_load_req_o    = word_start;
    assign underrun_pulse_o = word_start & ~tx_full_i;
    assign selected_o       = ss_low;
    assign miso_o           = active_q & tx_sh_q[d_width-1];

endmodule

// File: rtl/wb_spi_slave.sv
// Purpose : Wishbone-attached SPI slave: RX FIFO, tx holding register, sticky status, irq, register decode.
// Latency : wb_ack_o one cycle after request, read data registered with ack; rx word visible 1 clk after final rise pulse.
// Backpressure: Wishbone via ack; SPI has none - a word arriving at a full FIFO is dropped and flags overrun.
// Ports: clk/reset; wb (Wishbone slave modport); sclk_i/ss_n_i/mosi_i SPI pins; miso_o; irq_o level interrupt.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter int d_width    = 8,
    parameter int fifo_depth = 4
) (
    input  logic                clk,
    input  logic                reset,
    wb_spi_slave_if.slave       wb,
    input  logic                sclk_i,
    input  logic                ss_n_i,
    input  logic                mosi_i,
    output logic                miso_o,
    output logic                irq_o
);
    localparam int AW = $clog2(fifo_depth);

    logic [d_width-1:0] mem_q [fifo_depth];
    logic [d_width-1:0] mem_d [fifo_depth];
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [d_width-1:0] tx_hold_q, tx_hold_d;
    logic               tx_full_q, tx_full_d;
    logic               overrun_q, overrun_d, underrun_q, underrun_d, irq_en_q, irq_en_d;
    logic               ack_q, ack_d, pop_arm_q, pop_arm_d;
    logic [31:0]        dat_q, dat_d;

    logic [d_width-1:0] rx_word;
    logic               rx_push, tx_load_req, underrun_pulse, selected;
    logic               req, ack_out, wr_acc, fifo_empty, fifo_full, push, pop;
    logic [3:0]         reg_sel;
    logic [31:0]        rd_data;
    status_t            status;
    logic               unused_ok;

    spi_slave_core #(.d_width(d_width)) u_core (
        .clk              (clk),
        .reset            (reset),
        .sclk_i           (sclk_i),
        .ss_n_i           (ss_n_i),
        .mosi_i           (mosi_i),
        .tx_full_i        (tx_full_q),
        .tx_word_i        (tx_hold_q),
        .rx_word_o        (rx_word),
        .rx_push_o        (rx_push),
        .tx_load_req_o    (tx_load_req),
        .underrun_pulse_o (underrun_pulse),
        .selected_o       (selected),
        .miso_o           (miso_o)
    );

    always_comb begin
        req        = wb.wb_stb_i & wb.wb_cyc_i;
        ack_out    = ack_q & req;
        wr_acc     = ack_out & wb.wb_we_i;
        reg_sel    = wb.wb_adr_i[5:2];
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push       = rx_push & ~fifo_full;
        // Pop eligibility is fixed when the read data is captured, so a push
        // landing between capture and ack cannot be popped unseen.
        pop        = ack_out & pop_arm_q;

        status = '{selected: selected, underrun: underrun_q, overrun: overrun_q,
                   tx_empty: ~tx_full_q, rx_full: fifo_full, rx_valid: ~fifo_empty};

        case (reg_sel)
            REG_STATUS: rd_data = 32'(status);
            REG_RXDATA: rd_data = fifo_empty ? 32'd0 : 32'(mem_q[rd_ptr_q[AW-1:0]]);
            REG_CTRL:   rd_data = 32'(irq_en_q);
            default:    rd_data = 32'd0;
        endcase

        ack_d     = req & ~ack_q;
        dat_d     = (req && !ack_q && !wb.wb_we_i) ? rd_data : 32'd0;
        pop_arm_d = req & ~ack_q & ~wb.wb_we_i & (reg_sel == REG_RXDATA) & ~fifo_empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = rx_word;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        // A CPU write in the same cycle as a word-start load refills the
        // just-emptied register; the shifter already took the old value.
        tx_hold_d = tx_hold_q;
        tx_full_d = tx_full_q;
        if (tx_load_req) tx_full_d = 1'b0;
        if (wr_acc && reg_sel == REG_TXDATA) begin
            tx_hold_d = wb.wb_dat_i[d_width-1:0];
            tx_full_d = 1'b1;
        end

        irq_en_d = irq_en_q;
        if (wr_acc && reg_sel == REG_CTRL) irq_en_d = wb.wb_dat_i[0];

        // New events win over a simultaneous clear.
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (wr_acc && reg_sel == REG_STATUS) begin
            if (wb.wb_dat_i[ST_OVERRUN])  overrun_d  = 1'b0;
            if (wb.wb_dat_i[ST_UNDERRUN]) underrun_d = 1'b0;
        end
        if (rx_push && fifo_full) overrun_d  = 1'b1;
        if (underrun_pulse)       underrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            irq_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            pop_arm_q  <= 1'b0;
            dat_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_hold_q  <= tx_hold_d;
            tx_full_q  <= tx_full_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            irq_en_q   <= irq_en_d;
            ack_q      <= ack_d;
            pop_arm_q  <= pop_arm_d;
            dat_q      <= dat_d;
        end
    end

    assign wb.wb_ack_o = ack_out;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = irq_en_q & (~fifo_empty | overrun_q | underrun_q);

    // Byte selects and address bits outside [5:2] carry no meaning here.
    assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

endmodule

// File: doc/wb_spi_slave.md
# wb_spi_slave

Wishbone-attached SPI slave (mode 0, MSB first): the responder end of the bus driven by the SoC's SPI master. It samples an external SCLK/SS_n/MOSI on the system clock and buffers received words in a small RX FIFO read over Wishbone. It shifts out a CPU-loaded transmit word on MISO and flags overrun/underrun through sticky status bits and an optional interrupt.

## Interface
- d_width, 8: SPI word width in bits, 1..8.
- fifo_depth, 4: RX FIFO entries, power of two, ≥2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wb_stb_i / wb_cyc_i / wb_we_i  in  1  Wishbone strobe, cycle, write enable.
- wb_adr_i  in  32  byte address; bits [5:2] select the register.
- wb_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; bits above the field are 0.
- wb_ack_o  out  1  access acknowledge.
- sclk_i, ss_n_i, mosi_i  in  1  asynchronous SPI pins from the external master.
- miso_o  out  1  slave data out; driven 0 while deselected (no tristate).
- irq_o  out  1  level interrupt.

## Operation
- Registers are selected by wb_adr_i[5:2].
- 0 STATUS. Read: [0] rx_valid (FIFO not empty), [1] rx_full, [2] tx_empty, [3] overrun, [4] underrun, [5] selected (synchronized ss_n low). Write: 1 to bit 3 or 4 clears that sticky bit; other bits are ignored.
- 1 RXDATA. A read returns the FIFO head in [d_width-1:0] and pops it. A read while empty returns 0 and does not pop.
- 2 TXDATA. A write loads the tx holding register from [d_width-1:0] and clears tx_empty. A write while the holding register is full overwrites it.
- 3 CTRL. Bit 0 is irq_en (R/W).
- Any other address reads 0; writes to it have no effect.
- irq_o = irq_en & (rx_valid | overrun | underrun).
- Pin handling: sclk_i, ss_n_i and mosi_i each pass through 2-FF synchronizers. A third SCLK flop provides rise/fall pulses.
- Word start: on synchronized ss_n falling, and after each completed word while ss_n stays low:
  - if the holding register is full, its value moves to the tx shifter and tx_empty is set;
  - otherwise the shifter loads 0 and underrun is set.
- miso_o = shifter MSB while selected. The shifter advances on each SCLK fall pulse.
- Receive: on each SCLK rise pulse, synchronized MOSI shifts into the rx shifter LSB and the bit counter increments.
  - At d_width bits the word is pushed to the FIFO and the counter clears.
  - If the FIFO is full the word is dropped and overrun is set.
- ss_n rising mid-word: partial bits are discarded, the counter clears, nothing is pushed, and the tx shifter content is discarded.
- SCLK edges while ss_n is high are ignored.
- A push and a pop in the same cycle both take effect; the count is unchanged.
- The FIFO pointers are log2(fifo_depth)+1 bits. Full is signalled when the MSBs differ and the rest are equal; pointers wrap naturally.

## Timing
- Reset values are all zero: wb_ack_o, wb_dat_o, miso_o, irq_o, FIFO pointers, shifters, counter, sticky bits, irq_en. tx_empty resets to 1.
- Wishbone: wb_ack_o rises the cycle after stb&cyc with ack low, stays high for one cycle, and is gated by stb&cyc. Read data is registered and valid with ack. Register side effects (pop, load, clear) occur once, in the ack cycle.
- SCLK frequency must be ≤ clk/8 with ≥3 clk high and ≥3 clk low. SS_n setup to the first SCLK rise must be ≥4 clk.
- Pin-to-pulse latency is 3 clk. A received word is visible in STATUS.rx_valid 1 clk after the final rise pulse.
- miso_o changes 1 clk after the fall pulse (≤4 clk after the pin edge). The first bit is valid ≤4 clk after the ss_n pin falls.
- A TXDATA write landing in the same cycle as a word-start load goes to the now-empty holding register. The shifter takes the old value.
- Reset asserted mid-transfer aborts the transfer immediately. The next transfer is recognized only at the next ss_n falling edge.

## Structure
- Shared include file holds the register offsets (STATUS=0, RXDATA=1, TXDATA=2, CTRL=3) and the STATUS bit positions; the Wishbone driver reuses these.
- Sub-module spi_slave_core contains the synchronizers, edge detect, shifters, bit counter and word-start logic. It exposes rx_word/rx_push, tx_load_req/tx_word and underrun_pulse.
- The top level holds the FIFO, holding register, sticky bits and the Wishbone decode.

## Test plan
- Write TXDATA=0xA5; master sends 0x3C in one frame → MISO bits 1,0,1,0,0,1,0,1; RXDATA reads 0x3C; STATUS then reads tx_empty=1, rx_valid=0.
- 5 words 0x01..0x05 without reads at fifo_depth=4 → reads return 0x01..0x04, then 0; overrun=1; writing 0x08 to STATUS clears it.
- Frame with no TXDATA written → MISO all 0, underrun=1; with irq_en=1, irq_o=1 until cleared and the FIFO drained.
- ss_n rises after 5 bits, then a full 0x81 frame → only 0x81 in FIFO, no spurious push.
- Two back-to-back words in one ss_n low, TXDATA refilled between them with 0x11 then 0x22 → MISO carries 0x11 then 0x22, no underrun.
- Reset asserted mid-word → all outputs 0 next cycle, FIFO empty; a following frame is received correctly.
